// File: rtl/reg_write_arbiter_if.sv
// Requester-side write channel of the register-bank arbiter.
//   req   requester -> arbiter  request, held until gnt
//   op    requester -> arbiter  00 write, 01 set, 10 clear, 11 illegal
//   addr  requester -> arbiter  target register index
//   data  requester -> arbiter  write data (op 00 only)
//   gnt   arbiter -> requester  one-cycle grant pulse
interface reg_write_arbiter_if #(
    parameter int unsigned AW    = 2,
    parameter int unsigned WIDTH = 8
);
    logic             req;
    logic [1:0]       op;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             gnt;

    modport master (output req, output op, output addr, output data, input gnt);
    modport slave  (input req, input op, input addr, input data, output gnt);
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one NREG x WIDTH set/reset register bank between
// requester A (CPU control unit) and requester B (debug/loader port). Each granted
// request becomes registered one-hot load/set/reset strobes for the bank.
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   a, b        requester channels (req/op/addr/data in, gnt out)
//   reg_we      one-hot load strobe to bank
//   reg_set     one-hot synchronous-set strobe to bank
//   reg_rst     one-hot synchronous-reset strobe to bank
//   reg_wdata   bank D-input data, zero unless the granted op is a write
//   err         one-cycle pulse: granted op illegal or addr out of range
//   last_owner  0 = A, 1 = B; requester granted most recently
module reg_write_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4,
    parameter int unsigned AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    reg_write_arbiter_if.slave a,
    reg_write_arbiter_if.slave b,
    output logic [NREG-1:0]   reg_we,
    output logic [NREG-1:0]   reg_set,
    output logic [NREG-1:0]   reg_rst,
    output logic [WIDTH-1:0]  reg_wdata,
    output logic              err,
    output logic              last_owner
);

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_SET     = 2'b01,
        OP_CLEAR   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    logic             a_gnt_q;
    logic             b_gnt_q;

    logic             elig_a;
    logic             elig_b;
    logic             win_a;
    logic             win_b;
    logic             any_win;
    logic [1:0]       sel_op;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic             addr_ok;
    logic [NREG-1:0]  onehot;

    logic [NREG-1:0]  we_d;
    logic [NREG-1:0]  set_d;
    logic [NREG-1:0]  rst_d;
    logic [WIDTH-1:0] wdata_d;
    logic             err_d;

    assign a.gnt = a_gnt_q;
    assign b.gnt = b_gnt_q;

    // Arbitration: a requester in its grant cycle sits out this edge, which
    // also produces the A,B alternation when both hold their requests.
    always_comb begin
        elig_a   = a.req & ~a_gnt_q;
        elig_b   = b.req & ~b_gnt_q;
        win_a    = elig_a & (~elig_b | last_owner);
        win_b    = elig_b & (~elig_a | ~last_owner);
        any_win  = win_a | win_b;
        sel_op   = win_a ? a.op   : b.op;
        sel_addr = win_a ? a.addr : b.addr;
        sel_data = win_a ? a.data : b.data;
    end

    // Strobe decode of the winner's request; out-of-range addresses only flag err.
    always_comb begin
        we_d    = '0;
        set_d   = '0;
        rst_d   = '0;
        wdata_d = '0;
        err_d   = 1'b0;
        addr_ok = (32'(sel_addr) < NREG);
        onehot  = NREG'(1) << sel_addr;
        if (any_win) begin
            case (op_e'(sel_op))
                OP_WRITE: begin
                    wdata_d = sel_data;
                    if (addr_ok) we_d = onehot;
                    else         err_d = 1'b1;
                end
                OP_SET: begin
                    if (addr_ok) set_d = onehot;
                    else         err_d = 1'b1;
                end
                OP_CLEAR: begin
                    if (addr_ok) rst_d = onehot;
                    else         err_d = 1'b1;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Output registers; reset clears strobes at once and drops any pending grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            reg_we     <= '0;
            reg_set    <= '0;
            reg_rst    <= '0;
            reg_wdata  <= '0;
            err        <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            a_gnt_q   <= win_a;
            b_gnt_q   <= win_b;
            reg_we    <= we_d;
            reg_set   <= set_d;
            reg_rst   <= rst_d;
            reg_wdata <= wdata_d;
            err       <= err_d;
            if (any_win) last_owner <= win_b;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: table-driven cycle vectors on a 4-register instance
// with a bank model, plus hand sequences for alternation, out-of-range addresses
// (3-register instance), reset mid-operation and single-requester pacing.
module tb_reg_write_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] reg_we, reg_set, reg_rst;
    logic [7:0] reg_wdata;
    logic       err, last_owner;
    logic [2:0] reg_we3, reg_set3, reg_rst3;
    logic [7:0] reg_wdata3;
    logic       err3, last_owner3;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter_if #(.AW(2), .WIDTH(8)) ia ();
    reg_write_arbiter_if #(.AW(2), .WIDTH(8)) ib ();
    reg_write_arbiter_if #(.AW(2), .WIDTH(8)) ia3 ();
    reg_write_arbiter_if #(.AW(2), .WIDTH(8)) ib3 ();

    reg_write_arbiter #(.WIDTH(8), .NREG(4), .AW(2)) dut (
        .clk(clk), .reset(reset), .a(ia), .b(ib),
        .reg_we(reg_we), .reg_set(reg_set), .reg_rst(reg_rst),
        .reg_wdata(reg_wdata), .err(err), .last_owner(last_owner)
    );

    reg_write_arbiter #(.WIDTH(8), .NREG(3), .AW(2)) dut3 (
        .clk(clk), .reset(reset), .a(ia3), .b(ib3),
        .reg_we(reg_we3), .reg_set(reg_set3), .reg_rst(reg_rst3),
        .reg_wdata(reg_wdata3), .err(err3), .last_owner(last_owner3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the shared register bank.
    logic [7:0] bank [4];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset)           bank[i] <= 8'h00;
            else if (reg_rst[i]) bank[i] <= 8'h00;
            else if (reg_set[i]) bank[i] <= 8'hFF;
            else if (reg_we[i])  bank[i] <= reg_wdata;
        end
    end

    typedef struct {
        logic       a_req; logic [1:0] a_op; logic [1:0] a_addr; logic [7:0] a_data;
        logic       b_req; logic [1:0] b_op; logic [1:0] b_addr; logic [7:0] b_data;
        logic       e_agnt; logic e_bgnt;
        logic [3:0] e_we; logic [3:0] e_set; logic [3:0] e_rst;
        logic [7:0] e_wdata; logic e_err; logic e_last;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ia.req = 0; ia.op = 0; ia.addr = 0; ia.data = 0;
        ib.req = 0; ib.op = 0; ib.addr = 0; ib.data = 0;
        ia3.req = 0; ia3.op = 0; ia3.addr = 0; ia3.data = 0;
        ib3.req = 0; ib3.op = 0; ib3.addr = 0; ib3.data = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [23:0] obs();
        return {ia.gnt, ib.gnt, reg_we, reg_set, reg_rst, reg_wdata, err, last_owner};
    endfunction

    initial begin
        reset = 1'b1;
        idle_all();

        //          A: req op  addr data    B: req op  addr data   | agnt bgnt we     set     rst     wdata err last
        vecs[0]  = '{1, 2'd0, 2'd2, 8'hA5, 0, 2'd0, 2'd0, 8'h00, 1, 0, 4'b0100, 4'b0000, 4'b0000, 8'hA5, 0, 0};
        vecs[1]  = '{0, 2'd0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 8'h00, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 0};
        vecs[2]  = '{1, 2'd1, 2'd1, 8'h00, 1, 2'd1, 2'd3, 8'h00, 0, 1, 4'b0000, 4'b1000, 4'b0000, 8'h00, 0, 1};
        vecs[3]  = '{1, 2'd1, 2'd1, 8'h00, 1, 2'd1, 2'd3, 8'h00, 1, 0, 4'b0000, 4'b0010, 4'b0000, 8'h00, 0, 0};
        vecs[4]  = '{1, 2'd1, 2'd1, 8'h00, 1, 2'd1, 2'd3, 8'h00, 0, 1, 4'b0000, 4'b1000, 4'b0000, 8'h00, 0, 1};
        vecs[5]  = '{0, 2'd0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 8'h00, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 1};
        vecs[6]  = '{1, 2'd0, 2'd0, 8'h3C, 1, 2'd2, 2'd0, 8'h00, 1, 0, 4'b0001, 4'b0000, 4'b0000, 8'h3C, 0, 0};
        vecs[7]  = '{0, 2'd0, 2'd0, 8'h00, 1, 2'd2, 2'd0, 8'h00, 0, 1, 4'b0000, 4'b0000, 4'b0001, 8'h00, 0, 1};
        vecs[8]  = '{0, 2'd0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 8'h00, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 1};
        vecs[9]  = '{1, 2'd3, 2'd1, 8'h00, 0, 2'd0, 2'd0, 8'h00, 1, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1, 0};
        vecs[10] = '{1, 2'd2, 2'd3, 8'h00, 0, 2'd0, 2'd0, 8'h00, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 0};
        vecs[11] = '{1, 2'd2, 2'd3, 8'h00, 0, 2'd0, 2'd0, 8'h00, 1, 0, 4'b0000, 4'b0000, 4'b1000, 8'h00, 0, 0};
        vecs[12] = '{0, 2'd0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 8'h00, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 0};
        vecs[13] = '{0, 2'd0, 2'd0, 8'h00, 1, 2'd1, 2'd1, 8'h00, 0, 1, 4'b0000, 4'b0010, 4'b0000, 8'h00, 0, 1};
        vecs[14] = '{0, 2'd0, 2'd0, 8'h00, 1, 2'd0, 2'd1, 8'h5A, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 1};
        vecs[15] = '{0, 2'd0, 2'd0, 8'h00, 1, 2'd0, 2'd1, 8'h5A, 0, 1, 4'b0010, 4'b0000, 4'b0000, 8'h5A, 0, 1};
        vecs[16] = '{0, 2'd0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 8'h00, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 1};

        // Reset state while reset is asserted.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(obs()), 32'({1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1}));
        chk("reset_dut3", 32'({ib3.gnt, reg_we3, reg_set3, reg_rst3, err3, last_owner3}), 32'(14'b1));
        @(negedge clk);
        reset = 1'b0;

        // Table-driven cycle vectors.
        for (int i = 0; i < 17; i++) begin
            ia.req = vecs[i].a_req; ia.op = vecs[i].a_op; ia.addr = vecs[i].a_addr; ia.data = vecs[i].a_data;
            ib.req = vecs[i].b_req; ib.op = vecs[i].b_op; ib.addr = vecs[i].b_addr; ib.data = vecs[i].b_data;
            tick();
            chk($sformatf("vec%0d", i), 32'(obs()),
                32'({vecs[i].e_agnt, vecs[i].e_bgnt, vecs[i].e_we, vecs[i].e_set, vecs[i].e_rst,
                     vecs[i].e_wdata, vecs[i].e_err, vecs[i].e_last}));
            chk($sformatf("vec%0d_onehot", i), 32'($countones(reg_we | reg_set | reg_rst) <= 1), 32'd1);
        end
        chk("bank0", 32'(bank[0]), 32'h00);
        chk("bank1", 32'(bank[1]), 32'h5A);
        chk("bank2", 32'(bank[2]), 32'hA5);
        chk("bank3", 32'(bank[3]), 32'h00);

        // Both held from reset: A first, then strict alternation.
        idle_all();
        do_reset();
        ia.req = 1; ia.op = 2'd1; ia.addr = 2'd1;
        ib.req = 1; ib.op = 2'd1; ib.addr = 2'd3;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("alt%0d_gnt", k), 32'({ia.gnt, ib.gnt}), (k % 2 == 0) ? 32'h2 : 32'h1);
            chk($sformatf("alt%0d_set", k), 32'(reg_set), (k % 2 == 0) ? 32'h2 : 32'h8);
            chk($sformatf("alt%0d_last", k), 32'(last_owner), (k % 2 == 0) ? 32'h0 : 32'h1);
        end

        // Illegal op and out-of-range address on a 3-register bank.
        idle_all();
        do_reset();
        ib3.req = 1; ib3.op = 2'd3; ib3.addr = 2'd0;
        tick();
        chk("ill_op", 32'({ib3.gnt, err3, reg_we3, reg_set3, reg_rst3}), 32'({1'b1, 1'b1, 9'b0}));
        ib3.op = 2'd0; ib3.addr = 2'd3; ib3.data = 8'h11;
        tick();
        chk("oor_gap", 32'({ib3.gnt, err3}), 32'h0);
        tick();
        chk("oor_addr", 32'({ib3.gnt, err3, reg_we3, reg_set3, reg_rst3}), 32'({1'b1, 1'b1, 9'b0}));
        chk("oor_last", 32'(last_owner3), 32'h1);

        // Reset during the strobe cycle of a granted write.
        idle_all();
        do_reset();
        ia.req = 1; ia.op = 2'd0; ia.addr = 2'd1; ia.data = 8'h99;
        tick();
        chk("rst_pre", 32'({ia.gnt, reg_we, reg_wdata}), 32'({1'b1, 4'b0010, 8'h99}));
        reset = 1'b1;
        #1;
        chk("rst_mid", 32'({ia.gnt, reg_we, reg_wdata, last_owner}), 32'({1'b0, 4'b0, 8'h00, 1'b1}));
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("rst_regrant", 32'({ia.gnt, reg_we, reg_wdata, last_owner}), 32'({1'b1, 4'b0010, 8'h99, 1'b0}));

        // Single requester held: grant every other cycle.
        idle_all();
        do_reset();
        ia.req = 1; ia.op = 2'd2; ia.addr = 2'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("single%0d", k), 32'({ia.gnt, reg_rst}), (k % 2 == 0) ? 32'h11 : 32'h00);
        end

        idle_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
